axis_framer: RTL

AXI4-Stream framing stage that sits directly upstream of the frame-mode `axis_fifo`. It converts an unframed or loosely framed beat stream into bounded frames. A frame closes on any of four events: upstream tlast, a programmable maximum beat count, a tid/tdest change, or an idle timeout. A one-beat hold register lets the framer set tlast retroactively on the final beat, and tuser flags timeout-closed frames so the downstream FIFO can drop them with DROP_BAD_FRAME.

---
 rtl/axis_framer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axis_framer.sv
// rtl/axis_framer.sv - AXI-Stream framer: closes frames on tlast, length limit, tid/tdest change or idle timeout
module axis_framer #(
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int DEST_WIDTH    = 8,
  parameter int LEN_WIDTH     = 16,
  parameter int TIMEOUT       = 64,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  cfg_max_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  status_frame_done,
  output logic                  status_timeout,
  output logic [31:0]           status_frame_count
);

  localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT = TIMEOUT_WIDTH'(TIMEOUT);
  localparam bit TO_ENABLE = (TIMEOUT != 0);

  logic [DATA_WIDTH-1:0]    hold_data;
  logic [KEEP_WIDTH-1:0]    hold_keep;
  logic [ID_WIDTH-1:0]      hold_id;
  logic [DEST_WIDTH-1:0]    hold_dest;
  logic                     hold_last;
  logic                     hold_valid;
  logic [LEN_WIDTH-1:0]     beat_cnt;
  logic [LEN_WIDTH-1:0]     len_lat;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt;

  logic out_free;
  logic decided;
  logic s_fire;
  logic key_change;
  logic timeout_fire;
  logic emit;
  logic emit_last;

  always_comb begin
    out_free      = !m_axis_tvalid || m_axis_tready;
    decided       = hold_valid && (hold_last || (len_lat != '0 && beat_cnt == len_lat));
    s_axis_tready = rst && (!hold_valid || out_free);
    s_fire        = s_axis_tvalid && s_axis_tready;
    key_change    = (s_axis_tid != hold_id) || (s_axis_tdest != hold_dest);
    // An accepted beat outranks a timeout landing on the same edge.
    timeout_fire  = TO_ENABLE && hold_valid && !decided && !s_fire && out_free &&
                    (idle_cnt == TO_LIMIT);
    emit          = (decided && out_free) || (hold_valid && s_fire) || timeout_fire;
    emit_last     = decided || timeout_fire || key_change;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data          <= '0;
      hold_keep          <= '0;
      hold_id            <= '0;
      hold_dest          <= '0;
      hold_last          <= 1'b0;
      hold_valid         <= 1'b0;
      beat_cnt           <= '0;
      len_lat            <= '0;
      idle_cnt           <= '0;
      m_axis_tdata       <= '0;
      m_axis_tkeep       <= '0;
      m_axis_tid         <= '0;
      m_axis_tdest       <= '0;
      m_axis_tvalid      <= 1'b0;
      m_axis_tlast       <= 1'b0;
      m_axis_tuser       <= 1'b0;
      status_frame_done  <= 1'b0;
      status_timeout     <= 1'b0;
      status_frame_count <= '0;
    end else begin
      status_frame_done <= emit && emit_last;
      status_timeout    <= timeout_fire;
      if (emit && emit_last) begin
        status_frame_count <= status_frame_count + 32'd1;
      end

      if (emit) begin
        m_axis_tdata  <= hold_data;
        m_axis_tkeep  <= hold_keep;
        m_axis_tid    <= hold_id;
        m_axis_tdest  <= hold_dest;
        m_axis_tlast  <= emit_last;
        m_axis_tuser  <= timeout_fire;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      // The frame restarts whenever hold was empty or its beat just left carrying tlast.
      if (s_fire) begin
        hold_data  <= s_axis_tdata;
        hold_keep  <= s_axis_tkeep;
        hold_id    <= s_axis_tid;
        hold_dest  <= s_axis_tdest;
        hold_last  <= s_axis_tlast;
        hold_valid <= 1'b1;
        if (!hold_valid || emit_last) begin
          beat_cnt <= LEN_WIDTH'(1);
          len_lat  <= cfg_max_len;
        end else begin
          beat_cnt <= beat_cnt + LEN_WIDTH'(1);
        end
      end else if (emit) begin
        hold_valid <= 1'b0;
      end

      if (!hold_valid || s_fire || decided || timeout_fire) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TO_LIMIT) begin
        idle_cnt <= idle_cnt + TIMEOUT_WIDTH'(1);
      end
    end
  end

endmodule
